scroll_text_engine: RTL and testbench

Generates the scrolling 8-character instruction frame shown on the seven-segment display during the ATM prompting states. It decodes the 16-bit one-hot ATM state into one of four prompt messages, scrolls that message right-to-left through an 8-character window at a programmable rate, and presents a 40-bit frame (8 × 5-bit char codes) to the seven-segment display driver. It replaces the four per-message generators and their separate reset steering with one block that restarts cleanly on every state change.

---
 rtl/scroll_text_engine.sv | 143 ++++++++++++++
 tb/tb_scroll_text_engine.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/scroll_text_engine.sv
// Scrolls one of four ATM prompt messages through an 8-character seven-segment frame.
// Latency: msg_id/active 1 cycle after state; frame 2 cycles after a state change or step.
// Backpressure: none; hold freezes the prescaler and scroll position, but a state change still restarts.
module scroll_text_engine #(
    parameter int TICK_DIV = 100_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] state,
    input  logic        hold,
    output logic [39:0] frame,
    output logic [1:0]  msg_id,
    output logic        active,
    output logic        step
);
    localparam int            DW       = $clog2(TICK_DIV);
    localparam logic [DW-1:0] DIV_LAST = DW'(TICK_DIV - 1);

    localparam logic [4:0] CH_BL = 5'd31;
    localparam logic [4:0] CH_A  = 5'd10;
    localparam logic [4:0] CH_C  = 5'd12;
    localparam logic [4:0] CH_E  = 5'd14;
    localparam logic [4:0] CH_I  = 5'd18;
    localparam logic [4:0] CH_L  = 5'd20;
    localparam logic [4:0] CH_M  = 5'd21;
    localparam logic [4:0] CH_N  = 5'd22;
    localparam logic [4:0] CH_O  = 5'd23;
    localparam logic [4:0] CH_P  = 5'd24;
    localparam logic [4:0] CH_R  = 5'd25;
    localparam logic [4:0] CH_S  = 5'd26;
    localparam logic [4:0] CH_T  = 5'd27;
    localparam logic [4:0] CH_U  = 5'd28;
    localparam logic [4:0] CH_Y  = 5'd29;

    // Each message is padded to 15 characters; character 0 sits in the top 5 bits.
    localparam logic [74:0] TXT0 = {CH_E, CH_N, CH_T, CH_E, CH_R, CH_BL, CH_A, CH_C, CH_C,
                                    CH_BL, CH_N, CH_U, CH_M, CH_BL, CH_BL};
    localparam logic [74:0] TXT1 = {CH_E, CH_N, CH_T, CH_E, CH_R, CH_BL, CH_P, CH_I, CH_N,
                                    CH_BL, CH_BL, CH_BL, CH_BL, CH_BL, CH_BL};
    localparam logic [74:0] TXT2 = {CH_E, CH_N, CH_T, CH_E, CH_R, CH_BL, CH_A, CH_M, CH_O,
                                    CH_U, CH_N, CH_T, CH_BL, CH_BL, CH_BL};
    localparam logic [74:0] TXT3 = {CH_S, CH_E, CH_L, CH_E, CH_C, CH_T, CH_BL, CH_C, CH_U,
                                    CH_R, CH_R, CH_E, CH_N, CH_C, CH_Y};

    logic [4:0]    pos;
    logic [DW-1:0] div;
    logic          cur_active;
    logic [1:0]    cur_msg;
    logic          restart;
    logic [5:0]    period;
    logic [4:0]    pos_last;
    logic [5:0]    idx;
    logic [39:0]   frame_nxt;

    function automatic logic [4:0] stream_char(input logic [1:0] msg, input logic [4:0] s);
        logic [3:0]  c;
        logic [6:0]  base;
        logic [74:0] txt;
        if (s < 5'd8) begin
            return CH_BL;
        end
        c    = 4'(s - 5'd8);
        base = 7'(4'd14 - c) * 7'd5;
        case (msg)
            2'd0:    txt = TXT0;
            2'd1:    txt = TXT1;
            2'd2:    txt = TXT2;
            default: txt = TXT3;
        endcase
        return txt[base +: 5];
    endfunction

    always_comb begin
        cur_active = 1'b1;
        cur_msg    = 2'd0;
        case (state)
            16'h0002, 16'h0400:                     cur_msg = 2'd0;
            16'h0004:                               cur_msg = 2'd1;
            16'h0040, 16'h0100, 16'h0200, 16'h1000: cur_msg = 2'd2;
            16'h0020, 16'h0080, 16'h0800:           cur_msg = 2'd3;
            default:                                cur_active = 1'b0;
        endcase
    end

    assign restart = (cur_active != active) || (cur_msg != msg_id);

    always_comb begin
        case (msg_id)
            2'd0:    period = 6'd21;
            2'd1:    period = 6'd17;
            2'd2:    period = 6'd20;
            default: period = 6'd23;
        endcase
    end

    assign pos_last = 5'(period - 6'd1);

    // Window over the virtual stream; pos+k < 2P so one conditional subtract replaces the mod.
    always_comb begin
        frame_nxt = {8{CH_BL}};
        idx       = '0;
        if (active) begin
            for (int k = 0; k < 8; k++) begin
                idx = {1'b0, pos} + 6'(k);
                if (idx >= period) begin
                    idx = idx - period;
                end
                frame_nxt[(7 - k) * 5 +: 5] = stream_char(msg_id, idx[4:0]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pos    <= '0;
            div    <= '0;
            msg_id <= 2'd0;
            active <= 1'b0;
            step   <= 1'b0;
            frame  <= {8{CH_BL}};
        end else begin
            frame <= frame_nxt;
            step  <= 1'b0;
            if (restart) begin
                active <= cur_active;
                msg_id <= cur_msg;
                pos    <= '0;
                div    <= '0;
            end else if (!active) begin
                pos <= '0;
                div <= '0;
            end else if (!hold) begin
                if (div == DIV_LAST) begin
                    div  <= '0;
                    step <= 1'b1;
                    pos  <= (pos == pos_last) ? 5'd0 : pos + 5'd1;
                end else begin
                    div <= div + DW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_scroll_text_engine.sv
// Randomized scoreboard bench for scroll_text_engine; the reference model renders frames from message strings.
module tb_scroll_text_engine;
    localparam int TD = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] state;
    logic        hold;
    logic [39:0] frame;
    logic [1:0]  msg_id;
    logic        active;
    logic        step;

    scroll_text_engine #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .state  (state),
        .hold   (hold),
        .frame  (frame),
        .msg_id (msg_id),
        .active (active),
        .step   (step)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        act;
        logic [1:0]  msg;
        logic        stp;
        logic [39:0] frm;
    } exp_t;

    exp_t  sb[$];
    int    checks   = 0;
    int    failures = 0;

    string msgs[4]        = '{"ENTER ACC NUM", "ENTER PIN", "ENTER AMOUNT", "SELECT CURRENCY"};
    string alphabet       = "ABCDEFGHIJLMNOPRSTUYZ";
    int    msg_of_bit[16] = '{-1, 0, 1, -1, -1, 3, 2, 3, 2, 2, 0, 3, 2, -1, -1, -1};
    logic [15:0] legal[12] = '{16'h0001, 16'h0002, 16'h0004, 16'h0020, 16'h0040, 16'h0080,
                               16'h0100, 16'h0200, 16'h0400, 16'h0800, 16'h1000, 16'h0008};

    // Reference model registered state
    bit m_act;
    int m_msg;
    int m_pos;
    int m_div;

    function automatic logic [4:0] code_of(input byte ch);
        if (ch == " ") return 5'd31;
        if (ch >= "0" && ch <= "9") return 5'(ch - "0");
        for (int j = 0; j < alphabet.len(); j++)
            if (alphabet[j] == ch) return 5'(10 + j);
        return 5'd31;
    endfunction

    function automatic logic [39:0] render(input int m, input int p);
        string       t;
        int          per;
        int          i;
        logic [39:0] f;
        t   = msgs[m];
        per = t.len() + 8;
        f   = '1;
        for (int k = 0; k < 8; k++) begin
            i = (p + k) % per;
            f[(7 - k) * 5 +: 5] = (i < 8) ? 5'd31 : code_of(t[i - 8]);
        end
        return f;
    endfunction

    function automatic void decode(input logic [15:0] s, output bit a, output int m);
        a = 0;
        m = 0;
        if ($countones(s) == 1)
            for (int b = 0; b < 16; b++)
                if (s[b] && msg_of_bit[b] >= 0) begin
                    a = 1;
                    m = msg_of_bit[b];
                end
    endfunction

    // Drive inputs away from the edge, predict the outputs after the next posedge.
    task automatic tick(input logic [15:0] s, input logic h, input logic r);
        exp_t e;
        bit   ca;
        int   cm;
        @(negedge clk);
        state = s;
        hold  = h;
        rst_n = r;
        if (!r) begin
            m_act = 0; m_msg = 0; m_pos = 0; m_div = 0;
            e = '{1'b0, 2'd0, 1'b0, 40'hFF_FFFF_FFFF};
        end else begin
            e.frm = m_act ? render(m_msg, m_pos) : 40'hFF_FFFF_FFFF;
            e.stp = 1'b0;
            decode(s, ca, cm);
            if (ca != m_act || cm != m_msg) begin
                m_act = ca; m_msg = cm; m_pos = 0; m_div = 0;
            end else if (!m_act) begin
                m_pos = 0; m_div = 0;
            end else if (!h) begin
                if (m_div == TD - 1) begin
                    m_div = 0;
                    e.stp = 1'b1;
                    m_pos = (m_pos + 1) % (msgs[m_msg].len() + 8);
                end else begin
                    m_div++;
                end
            end
            e.act = m_act;
            e.msg = 2'(m_msg);
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, req);
        end
    endtask

    task automatic run_until_pos(input logic [15:0] s, input int target);
        int n = 0;
        while (m_pos != target && n < 400) begin
            tick(s, 1'b0, 1'b1);
            n++;
        end
        chk("pos_reach", 40'(m_pos), 40'(target));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("active", 40'(active), 40'(e.act));
                chk("msg_id", 40'(msg_id), 40'(e.msg));
                chk("step",   40'(step),   40'(e.stp));
                chk("frame",  frame,       e.frm);
            end
        end
    end

    initial begin : driver
        logic [15:0] s;
        int          len;
        int          n;
        rst_n = 1'b0;
        state = 16'h0002;
        hold  = 1'b0;
        m_act = 0; m_msg = 0; m_pos = 0; m_div = 0;

        repeat (3)  tick(16'h0002, 1'b0, 1'b0);
        repeat (30) tick(16'h0002, 1'b0, 1'b1);
        repeat (4 * 17 + 10) tick(16'h0004, 1'b0, 1'b1);

        run_until_pos(16'h0040, 10);
        repeat (14) tick(16'h0020, 1'b0, 1'b1);

        n = 0;
        while (m_div != TD - 1 && n < 10) begin
            tick(16'h0020, 1'b0, 1'b1);
            n++;
        end
        chk("div_reach", 40'(m_div), 40'(TD - 1));
        repeat (10) tick(16'h0080, 1'b0, 1'b1);

        run_until_pos(16'h0080, 5);
        repeat (2)  tick(16'h0080, 1'b0, 1'b1);
        repeat (20) tick(16'h0080, 1'b1, 1'b1);
        repeat (10) tick(16'h0080, 1'b0, 1'b1);
        repeat (4)  tick(16'h0800, 1'b1, 1'b1);
        repeat (6)  tick(16'h0800, 1'b0, 1'b1);

        repeat (5)  tick(16'h0006, 1'b0, 1'b1);
        repeat (5)  tick(16'h0001, 1'b0, 1'b1);
        repeat (40) tick(16'h0040, 1'b0, 1'b1);
        repeat (2)  tick(16'h0040, 1'b0, 1'b0);
        repeat (20) tick(16'h0040, 1'b0, 1'b1);

        repeat (60) begin
            if ($urandom_range(0, 9) < 7) s = legal[$urandom_range(0, 11)];
            else                          s = 16'($urandom);
            len = $urandom_range(5, 80);
            for (int c = 0; c < len; c++)
                tick(s, ($urandom_range(0, 9) == 0), ($urandom_range(0, 199) != 0));
        end

        @(posedge clk);
        #2;
        chk("sb_drained", 40'(sb.size()), 40'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
